mem_bus_arbiter: RTL and testbench

//  Shares the single RAM port (addressBus/dataOut/dataIn/enableWrite) between NREQ

---
 rtl/mem_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one RAM port between NREQ requesters with
// round-robin arbitration and exactly one transaction in flight.
// The RAM-side bus (addressBus/dataOut/enableWrite) is driven only while a
// transaction is on the bus and returns to zero otherwise.
module mem_bus_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 56,
  parameter int DATA_W  = 64,
  parameter int RAM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [ADDR_W-1:0]        addressBus,
  output logic [DATA_W-1:0]        dataOut,
  input  logic [DATA_W-1:0]        dataIn,
  output logic                     enableWrite
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(RAM_LAT + 1);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   grant_q, grant_d;
  logic               we_q, we_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic               found;
  logic [PTR_W-1:0]   win;

  // Next-state, round-robin pick and bus/handshake outputs.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    found       = 1'b0;
    win         = '0;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_data    = '0;
    addressBus  = '0;
    dataOut     = '0;
    enableWrite = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // First pass covers indices at or after the pointer, second pass wraps.
        for (int i = 0; i < NREQ; i++) begin
          if (!found && req_valid[i] && (PTR_W'(i) >= rr_ptr_q)) begin
            found = 1'b1;
            win   = PTR_W'(i);
          end
        end
        for (int i = 0; i < NREQ; i++) begin
          if (!found && req_valid[i]) begin
            found = 1'b1;
            win   = PTR_W'(i);
          end
        end
        if (found) begin
          grant_d = win;
          state_d = S_ISSUE;
          for (int i = 0; i < NREQ; i++) begin
            if (PTR_W'(i) == win) begin
              we_d    = req_we[i];
              addr_d  = req_addr[i*ADDR_W +: ADDR_W];
              wdata_d = req_wdata[i*DATA_W +: DATA_W];
            end
          end
        end
      end

      S_ISSUE: begin
        addressBus         = addr_q;
        dataOut            = wdata_q;
        enableWrite        = we_q;
        req_ready[grant_q] = 1'b1;
        rr_ptr_d           = (grant_q == PTR_MAX) ? '0 : grant_q + 1'b1;
        cnt_d              = '0;
        state_d            = we_q ? S_RESP : S_WAIT;
      end

      S_WAIT: begin
        addressBus = addr_q;
        dataOut    = wdata_q;
        if (cnt_q == CNT_LAST) begin
          rdata_d = dataIn;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        rsp_valid[grant_q] = 1'b1;
        rsp_data           = we_q ? '0 : rdata_q;
        state_d            = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, round-robin pointer, winner and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
    end
  end

  // Transaction payload; every output use is gated by the FSM state.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: RAM model, transaction-level reference model
// with round-robin grant prediction, directed and randomized scenarios.
module tb_mem_bus_arbiter;

  localparam int NREQ    = 2;
  localparam int ADDR_W  = 56;
  localparam int DATA_W  = 64;
  localparam int RAM_LAT = 1;
  localparam int MEM_N   = 256;
  localparam int OUT_W   = 2*NREQ + 2*DATA_W + ADDR_W + 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_we;
  logic [NREQ*ADDR_W-1:0]  req_addr;
  logic [NREQ*DATA_W-1:0]  req_wdata;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0]         rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic [ADDR_W-1:0]       addressBus;
  logic [DATA_W-1:0]       dataOut;
  logic [DATA_W-1:0]       dataIn;
  logic                    enableWrite;
  logic [OUT_W-1:0]        outs;

  int checks = 0;
  int errors = 0;

  logic                    preload = 1'b0;
  logic [DATA_W-1:0]       mem     [MEM_N];
  logic [DATA_W-1:0]       rd_pipe [RAM_LAT];
  logic [DATA_W-1:0]       model_mem [MEM_N];
  int                      model_ptr;
  int                      grants_q[$];

  typedef struct {
    int                g;
    logic [DATA_W-1:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  mem_bus_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .addressBus(addressBus), .dataOut(dataOut), .dataIn(dataIn), .enableWrite(enableWrite)
  );

  assign outs = {req_ready, rsp_valid, rsp_data, addressBus, dataOut, enableWrite};

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_val(input int a);
    if (a == 16) return 64'hDEADBEEF_CAFEF00D;
    return {32'hA5A5_0000 + 32'(a), 32'(a * 7 + 3)};
  endfunction

  // RAM: synchronous write, read data RAM_LAT cycles after the address cycle
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < MEM_N; k++) mem[k] <= init_val(k);
    end else if (enableWrite) begin
      mem[addressBus[7:0]] <= dataOut;
    end
    rd_pipe[0] <= mem[addressBus[7:0]];
    for (int k = 1; k < RAM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign dataIn = rd_pipe[RAM_LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first valid requester at or after ptr, cyclically
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
    int vm;
    vm = int'(v);
    for (int k = 0; k < NREQ; k++) begin
      if (((vm >> ((ptr + k) % NREQ)) & 1) != 0) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int vm;
    vm = int'(v);
    for (int k = 0; k < NREQ; k++) if (((vm >> k) & 1) != 0) return k;
    return -1;
  endfunction

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input int addr, input logic [DATA_W-1:0] wd);
    req_valid[i]                  = 1'b1;
    req_we[i]                     = we;
    req_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'(addr);
    req_wdata[i*DATA_W +: DATA_W] = wd;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst       = 1'b0;
    model_ptr = 0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic gen(input int i, input bit rd_only);
    set_req(i, rd_only ? 1'b0 : 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            {$urandom, $urandom});
  endtask

  // Drive traffic and check every grant and response against the model
  task automatic run_traffic(input int ntx, input int pct, input logic [NREQ-1:0] mask,
                             input bit rd_only);
    int issued, done, budget, g, eg, a;
    rsp_t r;
    issued = 0;
    done   = 0;
    budget = ntx * NREQ * (RAM_LAT + 4) + 50;
    grants_q.delete();
    exp_q.delete();
    for (int i = 0; i < NREQ; i++)
      if (mask[i] && issued < ntx && int'($urandom_range(0, 99)) < pct) begin
        gen(i, rd_only);
        issued++;
      end
    while (done < ntx && budget > 0) begin
      tick();
      budget--;
      checks++;
      if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1 ||
          (enableWrite && req_ready == '0)) begin
        errors++;
        $display("FAIL traffic_exclusive: ready=%b rsp_valid=%b enableWrite=%b, required <=1 bit each and enableWrite only with ready",
                 req_ready, rsp_valid, enableWrite);
      end
      if (req_ready != '0) begin
        g  = onehot_idx(req_ready);
        eg = rr_pick(req_valid, model_ptr);
        checks++;
        if (g != eg) begin
          errors++;
          $display("FAIL traffic_grant: granted %0d, required %0d", g, eg);
        end
        grants_q.push_back(g);
        if (g >= 0) begin
          a   = int'(req_addr[g*ADDR_W +: 8]);
          r.g = g;
          if (req_we[g]) begin
            model_mem[a] = req_wdata[g*DATA_W +: DATA_W];
            r.data       = '0;
          end else begin
            r.data = model_mem[a];
          end
          exp_q.push_back(r);
          model_ptr    = (g + 1) % NREQ;
          req_valid[g] = 1'b0;
        end
      end
      if (rsp_valid != '0) begin
        g = onehot_idx(rsp_valid);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL traffic_rsp_unexpected: rsp_valid=%b with nothing outstanding", rsp_valid);
        end else begin
          r = exp_q.pop_front();
          if (g != r.g || rsp_data !== r.data) begin
            errors++;
            $display("FAIL traffic_rsp: got req %0d data %h, required req %0d data %h",
                     g, rsp_data, r.g, r.data);
          end
        end
        done++;
      end
      for (int i = 0; i < NREQ; i++)
        if (mask[i] && !req_valid[i] && issued < ntx && int'($urandom_range(0, 99)) < pct) begin
          gen(i, rd_only);
          issued++;
        end
    end
    checks++;
    if (done != ntx) begin
      errors++;
      $display("FAIL traffic_timeout: completed %0d, required %0d", done, ntx);
    end
    clear_reqs();
  endtask

  task automatic test_reset();
    clear_reqs();
    rst     = 1'b0;
    preload = 1'b1;
    #1;
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_async: outputs %h, required 0", outs);
    end
    tick();
    preload = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (outs !== '0) begin
        errors++;
        $display("FAIL reset_idle: outputs %h, required 0", outs);
      end
    end
    set_req(0, 1'b1, 64, 64'h5555);
    tick();
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL reset_pre_issue: ready %b, required 01", req_ready);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_midcycle: outputs %h, required 0", outs);
    end
    clear_reqs();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (mem[64] !== init_val(64) || outs !== '0) begin
      errors++;
      $display("FAIL reset_abort_write: mem %h outputs %h, required mem %h outputs 0",
               mem[64], outs, init_val(64));
    end
  endtask

  task automatic test_read();
    do_reset();
    set_req(0, 1'b0, 16, '0);
    tick();
    checks++;
    if (req_ready !== 2'b01 || addressBus !== ADDR_W'(16) || enableWrite !== 1'b0) begin
      errors++;
      $display("FAIL read_issue: ready %b addr %h we %b, required 01 10 0",
               req_ready, addressBus, enableWrite);
    end
    req_valid = '0;
    for (int k = 0; k < RAM_LAT; k++) begin
      tick();
      checks++;
      if (rsp_valid !== 2'b00 || addressBus !== ADDR_W'(16) || enableWrite !== 1'b0) begin
        errors++;
        $display("FAIL read_wait: rsp_valid %b addr %h we %b, required 00 10 0",
                 rsp_valid, addressBus, enableWrite);
      end
    end
    tick();
    checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 64'hDEADBEEF_CAFEF00D || addressBus !== '0) begin
      errors++;
      $display("FAIL read_rsp: rsp_valid %b data %h addr %h, required 01 deadbeefcafef00d 0",
               rsp_valid, rsp_data, addressBus);
    end
    tick();
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL read_idle: outputs %h, required 0", outs);
    end
  endtask

  task automatic test_write();
    do_reset();
    set_req(1, 1'b1, 32, 64'h1234);
    checks++;
    if (enableWrite !== 1'b0) begin
      errors++;
      $display("FAIL write_idle_we: enableWrite %b, required 0", enableWrite);
    end
    tick();
    checks++;
    if (req_ready !== 2'b10 || enableWrite !== 1'b1 || addressBus !== ADDR_W'(32) ||
        dataOut !== 64'h1234) begin
      errors++;
      $display("FAIL write_issue: ready %b we %b addr %h data %h, required 10 1 20 1234",
               req_ready, enableWrite, addressBus, dataOut);
    end
    req_valid = '0;
    tick();
    checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== '0 || enableWrite !== 1'b0) begin
      errors++;
      $display("FAIL write_rsp: rsp_valid %b data %h we %b, required 10 0 0",
               rsp_valid, rsp_data, enableWrite);
    end
    checks++;
    if (mem[32] !== 64'h1234) begin
      errors++;
      $display("FAIL write_ram: RAM[0x20] %h, required 1234", mem[32]);
    end
    model_mem[32] = 64'h1234;
    tick();
    set_req(1, 1'b0, 32, '0);
    tick();
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL readback_issue: ready %b, required 10", req_ready);
    end
    req_valid = '0;
    for (int k = 0; k < RAM_LAT; k++) tick();
    tick();
    checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== 64'h1234) begin
      errors++;
      $display("FAIL readback_rsp: rsp_valid %b data %h, required 10 1234", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[4] = '{0, 1, 0, 1};
    do_reset();
    run_traffic(4, 100, 2'b11, 1'b1);
    checks++;
    if (grants_q.size() != 4) begin
      errors++;
      $display("FAIL rr_count: %0d grants, required 4", grants_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (grants_q[k] != exp_order[k]) begin
          errors++;
          $display("FAIL rr_order[%0d]: granted %0d, required %0d", k, grants_q[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    do_reset();
    run_traffic(6, 100, 2'b01, 1'b0);
    n0 = 0;
    foreach (grants_q[k]) if (grants_q[k] == 0) n0++;
    checks++;
    if (n0 != 6 || grants_q.size() != 6) begin
      errors++;
      $display("FAIL single_req: %0d of %0d grants to req0, required 6 of 6", n0, grants_q.size());
    end
  endtask

  task automatic test_reset_mid();
    // Abort a req1 read in WAIT; req1 still pending must be served first afterwards.
    do_reset();
    set_req(1, 1'b0, 48, '0);
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL midreset_async: outputs %h, required 0", outs);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (rsp_valid !== '0) begin
        errors++;
        $display("FAIL midreset_no_rsp: rsp_valid %b, required 00", rsp_valid);
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL midreset_regrant: ready %b, required 10", req_ready);
    end
    req_valid = '0;
    for (int k = 0; k < RAM_LAT; k++) tick();
    tick();
    checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== model_mem[48]) begin
      errors++;
      $display("FAIL midreset_rsp: rsp_valid %b data %h, required 10 %h",
               rsp_valid, rsp_data, model_mem[48]);
    end
    // Abort after req0 moved the pointer; the pointer must be back at 0.
    do_reset();
    set_req(0, 1'b0, 49, '0);
    tick();
    req_valid = '0;
    tick();
    #2 rst = 1'b0;
    #1;
    tick();
    rst = 1'b1;
    set_req(0, 1'b0, 50, '0);
    set_req(1, 1'b0, 51, '0);
    tick();
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL midreset_ptr: ready %b, required 01", req_ready);
    end
    clear_reqs();
    repeat (RAM_LAT + 2) tick();
  endtask

  task automatic test_random();
    do_reset();
    run_traffic(40, 40, 2'b11, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < MEM_N; k++) model_mem[k] = init_val(k);
    model_ptr = 0;
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
